// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between eight requesters and the mux arbiter.
// The master side drives requests; the arbiter side returns the grant.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  valid
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output valid
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of an 8:1 mux.
// Bounds one owner's tenure to MAX_HOLD cycles under contention.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux8_rr_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e      state_q, state_d;
  logic [7:0]  gnt_q, gnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        valid_q, valid_d;
  logic [3:0]  hold_q, hold_d;
  logic [2:0]  ptr_q, ptr_d;

  logic [7:0]  own_oh;
  logic [7:0]  cand;
  logic [2:0]  pick;
  logic        own;
  logic        other;
  logic        at_max;
  logic        rel_go;
  logic        rel_idle;
  logic        preempt;
  logic        stay;

  assign own_oh = 8'b1 << sel_q;

  // Owner is masked out while granting, so a pick never re-selects it.
  assign cand = (state_q == GRANT) ? (bus.req & ~own_oh) : bus.req;

  assign own      = bus.req[sel_q];
  assign other    = |cand;
  assign at_max   = (hold_q == 4'(MAX_HOLD));
  assign rel_go   = !own && other;
  assign rel_idle = !own && !other;
  assign preempt  = own && at_max && other;
  assign stay     = own && !(at_max && other);

  // Nearest set bit after ptr wins; scanning backwards lets it land last.
  always_comb begin
    logic [2:0] idx;
    pick = ptr_q;
    for (int k = 8; k >= 1; k--) begin
      idx = ptr_q + 3'(k);
      if (cand[idx]) pick = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
      hold_q  <= 4'd0;
      ptr_q   <= 3'd7;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|bus.req) state_d = GRANT;
      GRANT:   if (rel_idle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = 8'b1 << pick;
          sel_d   = pick;
          valid_d = 1'b1;
          hold_d  = 4'd1;
          ptr_d   = pick;
        end
      end
      GRANT: begin
        unique case (1'b1)
          rel_go, preempt: begin
            gnt_d   = 8'b1 << pick;
            sel_d   = pick;
            valid_d = 1'b1;
            hold_d  = 4'd1;
            ptr_d   = pick;
          end
          rel_idle: begin
            gnt_d   = 8'h00;
            valid_d = 1'b0;
            hold_d  = 4'd0;
          end
          stay: begin
            if (!at_max) hold_d = hold_q + 4'd1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;

endmodule
